rv_exwb: RTL and testbench
==========================

RV_EXWB -- requirements
Module: rv_exwb

Interface
REQ-001 Parameter TMO_CYC, default 64: max BUSY cycles before muldiv timeout abort; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 xreset  input  1  reset, asynchronous, active-low.
REQ-004 rdy  input  1  global pipeline enable; low freezes all state.
REQ-005 ex_valid  input  1  execute-stage instruction valid this cycle.
REQ-006 ex_wen  input  1  instruction writes rd.
REQ-007 ex_rd  input  5  destination register index.
REQ-008 flush  input  1  squash the execute-stage instruction / pending write.
REQ-009 rwdat  input  32  single-cycle ALU result.
REQ-010 rwdatx  input  32  mul/div result, valid when cmpl=1.
REQ-011 mulop  input  1  execute-stage op is mul/div.
REQ-012 cmpl  input  1  mul/div result complete this cycle.
REQ-013 id_rs1, id_rs2  input  5 each  decode-stage source indices for hazard check.
REQ-014 stall  output  1  hold upstream stages (combinational).
REQ-015 hz  output  1  RAW hazard against pending mul/div rd (combinational).
REQ-016 wb_we  output  1  register-file write enable.
REQ-017 wb_rd  output  5  register-file write index.
REQ-018 wb_dat  output  32  register-file write data; also forwarding source.
REQ-019 tmo_err  output  1  sticky mul/div timeout flag.

Function
REQ-020 States: IDLE, BUSY; state, pend_rd, pend_wen, pend_kill, busy_cnt (8 bit), wb_we/wb_rd/wb_dat, tmo_err are registers.
REQ-021 rdy=0: every register holds; wb_we output forced 0; stall=1.
REQ-022 IDLE, ex_valid=1, flush=0, mulop=0: next edge wb_we=ex_wen&(ex_rd!=0), wb_rd=ex_rd, wb_dat=rwdat (latency 1).
REQ-023 IDLE, ex_valid=1, flush=0, mulop=1, cmpl=1: same as REQ-022 but wb_dat=rwdatx; stay IDLE.
REQ-024 IDLE, ex_valid=1, flush=0, mulop=1, cmpl=0: stall=1 this cycle; next edge -> BUSY, pend_rd=ex_rd, pend_wen=ex_wen, pend_kill=0, busy_cnt=1, wb_we=0.
REQ-025 IDLE with ex_valid=0 or flush=1: next edge wb_we=0; wb_rd/wb_dat hold.
REQ-026 BUSY, cmpl=0: stall=1; busy_cnt+=1; wb_we=0; ex_valid ignored.
REQ-027 BUSY, cmpl=1: stall=0 same cycle; next edge -> IDLE, wb_we=pend_wen&~pend_kill&~flush&(pend_rd!=0), wb_rd=pend_rd, wb_dat=rwdatx.
REQ-028 BUSY, flush=1: pend_kill set next edge; remain BUSY until cmpl or timeout; no write results.
REQ-029 BUSY, cmpl=0 and busy_cnt=TMO_CYC: next edge -> IDLE, tmo_err=1, wb_we=0, stall released that cycle.
REQ-030 tmo_err sticky; cleared only by reset.
REQ-031 hz=(state==BUSY)&pend_wen&~pend_kill&(pend_rd!=0)&((id_rs1==pend_rd)|(id_rs2==pend_rd)).
REQ-032 Writes to x0 never assert wb_we; wb_rd/wb_dat still update.
REQ-033 cmpl seen in IDLE with mulop=0 is ignored.
REQ-034 stall in IDLE = ex_valid&~flush&mulop&~cmpl; in BUSY = ~cmpl & (busy_cnt!=TMO_CYC); OR'd with ~rdy.
REQ-035 wb_we is a single-cycle pulse per retired instruction; never asserted two cycles for one instruction.

Reset
REQ-036 xreset=0 asynchronously: state=IDLE, all registers and outputs 0, stall=0, hz=0, tmo_err=0.
REQ-037 Reset during BUSY aborts the pending op with no write; first edge after release behaves as IDLE.

Verification
REQ-038 ADD x5 result 0x0000_1234, ex_valid=1, mulop=0 -> next cycle wb_we=1, wb_rd=5, wb_dat=0x0000_1234, stall never 1.
REQ-039 DIV rd=7, cmpl after 33 cycles, rwdatx=0xFFFF_FFFD -> stall=1 for 33 cycles, hz=1 when id_rs2=7, then wb_we=1 one cycle with wb_dat=0xFFFF_FFFD.
REQ-040 MUL with cmpl same cycle, rd=0 -> no stall, wb_we=0, wb_dat=rwdatx.
REQ-041 DIV rd=9, flush pulse in BUSY cycle 3, cmpl at cycle 10 -> hz drops after flush, wb_we stays 0, IDLE after cmpl.
REQ-042 TMO_CYC=64, mulop with cmpl never -> stall high 64 cycles, then tmo_err=1, IDLE, wb_we=0.
REQ-043 xreset pulsed low mid-BUSY, rdy toggled low during BUSY -> outputs zero on reset; with rdy=0 busy_cnt and state frozen.

Source files
------------

// File: rtl/rv_exwb.sv
// Execute/writeback stage: retires ALU and mul/div results to the register file,
// stalls upstream while a mul/div is outstanding and aborts it on timeout.
module rv_exwb #(
  parameter int unsigned TMO_CYC = 64
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic        rdy,
  input  logic        ex_valid,
  input  logic        ex_wen,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  input  logic [31:0] rwdat,
  input  logic [31:0] rwdatx,
  input  logic        mulop,
  input  logic        cmpl,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic        stall,
  output logic        hz,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_dat,
  output logic        tmo_err
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [REG_W-1:0]   pend_rd_q, pend_rd_d;
  logic               pend_wen_q, pend_wen_d;
  logic               pend_kill_q, pend_kill_d;
  logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic               wb_we_q, wb_we_d;
  logic [REG_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DAT_W-1:0]   wb_dat_q, wb_dat_d;
  logic               tmo_err_q, tmo_err_d;

  logic issue;
  logic at_limit;
  logic pend_live;
  logic stall_core;

  assign issue     = ex_valid & ~flush;
  assign at_limit  = (busy_cnt_q == TMO_LIM);
  // A pending op only produces a real write if it targets a non-zero rd and was not squashed.
  assign pend_live = pend_wen_q & ~pend_kill_q & (pend_rd_q != '0);

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q     <= S_IDLE;
      pend_rd_q   <= '0;
      pend_wen_q  <= 1'b0;
      pend_kill_q <= 1'b0;
      busy_cnt_q  <= '0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_dat_q    <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_wen_q  <= pend_wen_d;
      pend_kill_q <= pend_kill_d;
      busy_cnt_q  <= busy_cnt_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_dat_q    <= wb_dat_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  // Next-state and writeback logic; with rdy low every register simply holds.
  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_wen_d  = pend_wen_q;
    pend_kill_d = pend_kill_q;
    busy_cnt_d  = busy_cnt_q;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_dat_d    = wb_dat_q;
    tmo_err_d   = tmo_err_q;
    stall_core  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stall_core = issue & mulop & ~cmpl;
        if (rdy) begin
          wb_we_d = 1'b0;
          if (issue) begin
            if (!mulop || cmpl) begin
              wb_we_d  = ex_wen & (ex_rd != '0);
              wb_rd_d  = ex_rd;
              wb_dat_d = mulop ? rwdatx : rwdat;
            end else begin
              state_d     = S_BUSY;
              pend_rd_d   = ex_rd;
              pend_wen_d  = ex_wen;
              pend_kill_d = 1'b0;
              busy_cnt_d  = CNT_W'(1);
            end
          end
        end
      end
      S_BUSY: begin
        stall_core = ~cmpl & ~at_limit;
        if (rdy) begin
          wb_we_d = 1'b0;
          if (cmpl) begin
            state_d  = S_IDLE;
            wb_we_d  = pend_live & ~flush;
            wb_rd_d  = pend_rd_q;
            wb_dat_d = rwdatx;
          end else if (at_limit) begin
            state_d   = S_IDLE;
            tmo_err_d = 1'b1;
          end else begin
            busy_cnt_d = busy_cnt_q + CNT_W'(1);
            if (flush) begin
              pend_kill_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Held-off write pulse is masked while the pipeline is frozen; stall is quiet in reset.
  assign wb_we   = wb_we_q & rdy;
  assign wb_rd   = wb_rd_q;
  assign wb_dat  = wb_dat_q;
  assign tmo_err = tmo_err_q;
  assign stall   = xreset & (~rdy | stall_core);
  assign hz      = (state_q == S_BUSY) & pend_live &
                   ((id_rs1 == pend_rd_q) | (id_rs2 == pend_rd_q));

endmodule

// File: tb/tb_rv_exwb.sv
// Randomised scoreboard bench for rv_exwb: transaction-level model of retirement,
// stall, hazard and timeout behaviour, with a decoupled write monitor.
module tb_rv_exwb;

  localparam int unsigned TMO = 64;

  logic        clk;
  logic        xreset;
  logic        rdy;
  logic        ex_valid;
  logic        ex_wen;
  logic [4:0]  ex_rd;
  logic        flush;
  logic [31:0] rwdat;
  logic [31:0] rwdatx;
  logic        mulop;
  logic        cmpl;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        stall;
  logic        hz;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_dat;
  logic        tmo_err;

  rv_exwb #(.TMO_CYC(TMO)) dut (
    .clk(clk), .xreset(xreset), .rdy(rdy), .ex_valid(ex_valid), .ex_wen(ex_wen),
    .ex_rd(ex_rd), .flush(flush), .rwdat(rwdat), .rwdatx(rwdatx), .mulop(mulop),
    .cmpl(cmpl), .id_rs1(id_rs1), .id_rs2(id_rs2), .stall(stall), .hz(hz),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_dat(wb_dat), .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_w;
  int          n_chk;
  int          n_fail;
  logic [4:0]  m_rd;
  logic [31:0] m_dat;
  logic        m_tmo;
  logic        m_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] rnd5();
    return 5'($urandom);
  endfunction

  function automatic logic [4:0] pick(input logic [4:0] rd);
    return ($urandom_range(2, 0) == 0) ? rd : 5'($urandom);
  endfunction

  // One cycle: drive inputs just after negedge, check combinational and held state, wait a cycle.
  task automatic step(input logic v, input logic we, input logic [4:0] rd, input logic fl,
                      input logic [31:0] rw, input logic [31:0] rwx, input logic mul,
                      input logic cm, input logic [4:0] r1, input logic [4:0] r2,
                      input logic rdy_v, input logic e_stall, input logic e_hz);
    ex_valid = v;  ex_wen = we;  ex_rd = rd;  flush = fl;
    rwdat = rw;    rwdatx = rwx; mulop = mul; cmpl = cm;
    id_rs1 = r1;   id_rs2 = r2;  rdy = rdy_v;
    #1;
    chk("stall",   32'(stall),   32'(e_stall));
    chk("hz",      32'(hz),      32'(e_hz));
    chk("wb_rd_held",  32'(wb_rd), 32'(m_rd));
    chk("wb_dat_held", wb_dat,     m_dat);
    chk("tmo_err", 32'(tmo_err), 32'(m_tmo));
    chk("wb_we",   32'(wb_we),   32'(rdy_v ? m_we : 1'b0));
    if (rdy_v) m_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_wr(input logic [4:0] rd, input logic [31:0] dat);
    wr_t w;
    w.rd  = rd;
    w.dat = dat;
    exp_q.push_back(w);
  endtask

  task automatic alu(input logic [4:0] rd, input logic we, input logic fl, input logic [31:0] dat);
    logic mul;
    logic wr;
    mul = fl ? 1'($urandom) : 1'b0;
    wr  = !fl && we && (rd != 5'd0);
    if (wr) push_wr(rd, dat);
    step(1'b1, we, rd, fl, dat, $urandom, mul, 1'($urandom), rnd5(), rnd5(), 1'b1, 1'b0, 1'b0);
    if (!fl) begin
      m_rd  = rd;
      m_dat = dat;
    end
    m_we = wr;
  endtask

  task automatic bubble(input logic rdy_v);
    step(rdy_v ? 1'b0 : 1'($urandom), 1'($urandom), rnd5(), 1'($urandom), $urandom, $urandom,
         1'($urandom), 1'($urandom), rnd5(), rnd5(), rdy_v, !rdy_v, 1'b0);
  endtask

  // Mul/div issue: lat=0 completes on issue, otherwise on the lat-th busy cycle.
  // flush_at names a busy cycle to squash in (0 = none); stop_b>0 leaves the op in flight.
  task automatic muldiv(input logic [4:0] rd, input logic we, input int lat, input int flush_at,
                        input logic gaps, input logic [31:0] fixed_dat, input logic use_fixed,
                        input int stop_b);
    logic [31:0] rx;
    logic        killed;
    logic        done;
    logic        to;
    logic        fl;
    logic        wr;
    logic        eh;
    logic [4:0]  r1;
    logic [4:0]  r2;
    int          b;
    rx = use_fixed ? fixed_dat : $urandom;
    if (lat == 0) begin
      wr = we && (rd != 5'd0);
      if (wr) push_wr(rd, rx);
      step(1'b1, we, rd, 1'b0, $urandom, rx, 1'b1, 1'b1, rnd5(), rnd5(), 1'b1, 1'b0, 1'b0);
      m_rd  = rd;
      m_dat = rx;
      m_we  = wr;
      return;
    end
    step(1'b1, we, rd, 1'b0, $urandom, $urandom, 1'b1, 1'b0, rnd5(), rnd5(), 1'b1, 1'b1, 1'b0);
    killed = 1'b0;
    b = 1;
    forever begin
      if (stop_b != 0 && b > stop_b) return;
      r1 = pick(rd);
      r2 = pick(rd);
      eh = we && (rd != 5'd0) && !killed && (r1 == rd || r2 == rd);
      if (gaps && $urandom_range(5, 0) == 0) begin
        step(1'($urandom), 1'($urandom), rnd5(), 1'($urandom), $urandom, $urandom,
             1'($urandom), 1'($urandom), r1, r2, 1'b0, 1'b1, eh);
        continue;
      end
      done = (b == lat);
      to   = (b == int'(TMO)) && !done;
      fl   = (b == flush_at);
      wr   = done && we && !killed && !fl && (rd != 5'd0);
      if (wr) push_wr(rd, rx);
      step(1'($urandom), 1'($urandom), rnd5(), fl, $urandom, done ? rx : $urandom,
           1'($urandom), done, r1, r2, 1'b1, !done && !to, eh);
      if (done) begin
        m_rd  = rd;
        m_dat = rx;
        m_we  = wr;
        return;
      end
      if (to) begin
        m_tmo = 1'b1;
        return;
      end
      if (fl) killed = 1'b1;
      b++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wb_we"},   32'(wb_we),   32'd0);
    chk({tag, "_wb_rd"},   32'(wb_rd),   32'd0);
    chk({tag, "_wb_dat"},  wb_dat,       32'd0);
    chk({tag, "_tmo_err"}, 32'(tmo_err), 32'd0);
    chk({tag, "_stall"},   32'(stall),   32'd0);
    chk({tag, "_hz"},      32'(hz),      32'd0);
  endtask

  // Write monitor: every presented write pulse must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (xreset === 1'b1 && wb_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(wb_we), 32'd0);
        end else begin
          mon_w = exp_q.pop_front();
          chk("mon_wb_rd",  32'(wb_rd), 32'(mon_w.rd));
          chk("mon_wb_dat", wb_dat,     mon_w.dat);
        end
      end
    end
  end

  initial begin
    n_chk = 0;  n_fail = 0;
    m_rd = '0;  m_dat = '0;  m_tmo = 1'b0;  m_we = 1'b0;
    xreset = 1'b0;  rdy = 1'b0;  ex_valid = 1'b1;  ex_wen = 1'b1;  ex_rd = 5'd3;
    flush = 1'b0;   rwdat = '0;  rwdatx = '0;      mulop = 1'b1;   cmpl = 1'b0;
    id_rs1 = '0;    id_rs2 = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    ex_valid = 1'b0;  mulop = 1'b0;  rdy = 1'b1;
    xreset = 1'b1;

    alu(5'd5, 1'b1, 1'b0, 32'h0000_1234);
    bubble(1'b1);
    muldiv(5'd7, 1'b1, 33, 0, 1'b0, 32'hFFFF_FFFD, 1'b1, 0);
    bubble(1'b1);
    muldiv(5'd0, 1'b1, 0, 0, 1'b0, 32'h0, 1'b0, 0);
    muldiv(5'd9, 1'b1, 10, 3, 1'b0, 32'h0, 1'b0, 0);
    bubble(1'b1);
    alu(5'd17, 1'b1, 1'b0, 32'hCAFE_0017);
    bubble(1'b0);
    bubble(1'b0);
    bubble(1'b1);
    alu(5'd0, 1'b1, 1'b0, 32'h0BAD_0000);
    alu(5'd21, 1'b0, 1'b0, 32'h0000_0021);
    alu(5'd22, 1'b1, 1'b1, 32'hDEAD_0022);
    alu(5'd1, 1'b1, 1'b0, 32'h1111_1111);
    alu(5'd2, 1'b1, 1'b0, 32'h2222_2222);

    for (int i = 0; i < 200; i++) begin
      int lat;
      int fa;
      logic [4:0] rd;
      rd = ($urandom_range(7, 0) == 0) ? 5'd0 : rnd5();
      case ($urandom_range(3, 0))
        0: alu(rd, 1'($urandom), ($urandom_range(7, 0) == 0), $urandom);
        1: bubble($urandom_range(3, 0) != 0);
        default: begin
          lat = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(40, 1));
          fa  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 1)) : 0;
          muldiv(rd, 1'($urandom), lat, fa, 1'($urandom), 32'h0, 1'b0, 0);
        end
      endcase
    end

    muldiv(5'd15, 1'b1, 1000, 0, 1'b1, 32'h0, 1'b0, 0);
    alu(5'd4, 1'b1, 1'b0, 32'h4444_0004);
    bubble(1'b1);

    muldiv(5'd12, 1'b1, 1000, 0, 1'b1, 32'h0, 1'b0, 6);
    ex_valid = 1'b1;  mulop = 1'b1;  cmpl = 1'b0;  rdy = 1'b0;
    id_rs1 = 5'd12;   id_rs2 = 5'd12;
    #2;
    xreset = 1'b0;
    #1;
    check_reset_outputs("mid_busy_reset");
    m_rd = '0;  m_dat = '0;  m_tmo = 1'b0;  m_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("held_reset");
    ex_valid = 1'b0;  mulop = 1'b0;  rdy = 1'b1;
    xreset = 1'b1;
    alu(5'd3, 1'b1, 1'b0, 32'hA5A5_0001);
    bubble(1'b1);
    bubble(1'b1);

    chk("expected_writes_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
